// File: rtl/rvfi_retire_buffer.sv
// In-order retirement buffer feeding a single-channel RVFI port.
// Issue records enter at the tail and completions may arrive in any order.
// Each retired entry produces exactly one sanitised packet, in program order.
module rvfi_retire_buffer #(
   parameter int XLEN  = 32,
   parameter int ILEN  = 32,
   parameter int DEPTH = 4,
   parameter int TW    = $clog2(DEPTH)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              i_iss_valid,
   output logic              o_iss_ready,
   output logic [TW-1:0]     o_iss_tag,
   input  logic [ILEN-1:0]   i_iss_insn,
   input  logic              i_iss_intr,
   input  logic [XLEN-1:0]   i_iss_pc_rdata,
   input  logic [4:0]        i_iss_rs1_addr,
   input  logic [4:0]        i_iss_rs2_addr,
   input  logic [XLEN-1:0]   i_iss_rs1_rdata,
   input  logic [XLEN-1:0]   i_iss_rs2_rdata,
   input  logic              i_cmp_valid,
   input  logic [TW-1:0]     i_cmp_tag,
   input  logic              i_cmp_trap,
   input  logic              i_cmp_halt,
   input  logic [4:0]        i_cmp_rd_addr,
   input  logic [XLEN-1:0]   i_cmp_rd_wdata,
   input  logic [XLEN-1:0]   i_cmp_pc_wdata,
   input  logic [XLEN-1:0]   i_cmp_mem_addr,
   input  logic [XLEN-1:0]   i_cmp_mem_rdata,
   input  logic [XLEN-1:0]   i_cmp_mem_wdata,
   input  logic [XLEN/8-1:0] i_cmp_mem_rmask,
   input  logic [XLEN/8-1:0] i_cmp_mem_wmask,
   input  logic              i_flush,
   input  logic [TW-1:0]     i_flush_tag,
   output logic              o_rvfi_valid,
   output logic [63:0]       o_rvfi_order,
   output logic [ILEN-1:0]   o_rvfi_insn,
   output logic              o_rvfi_trap,
   output logic              o_rvfi_halt,
   output logic              o_rvfi_intr,
   output logic [4:0]        o_rvfi_rs1_addr,
   output logic [4:0]        o_rvfi_rs2_addr,
   output logic [XLEN-1:0]   o_rvfi_rs1_rdata,
   output logic [XLEN-1:0]   o_rvfi_rs2_rdata,
   output logic [4:0]        o_rvfi_rd_addr,
   output logic [XLEN-1:0]   o_rvfi_rd_wdata,
   output logic [XLEN-1:0]   o_rvfi_pc_rdata,
   output logic [XLEN-1:0]   o_rvfi_pc_wdata,
   output logic [XLEN-1:0]   o_rvfi_mem_addr,
   output logic [XLEN/8-1:0] o_rvfi_mem_rmask,
   output logic [XLEN/8-1:0] o_rvfi_mem_wmask,
   output logic [XLEN-1:0]   o_rvfi_mem_rdata,
   output logic [XLEN-1:0]   o_rvfi_mem_wdata
);

   localparam int MW = XLEN / 8;

   typedef struct packed {
      logic [ILEN-1:0] insn;
      logic            intr;
      logic [XLEN-1:0] pc_rdata;
      logic [4:0]      rs1_addr;
      logic [4:0]      rs2_addr;
      logic [XLEN-1:0] rs1_rdata;
      logic [XLEN-1:0] rs2_rdata;
   } iss_rec_t;

   typedef struct packed {
      logic            trap;
      logic            halt;
      logic [4:0]      rd_addr;
      logic [XLEN-1:0] rd_wdata;
      logic [XLEN-1:0] pc_wdata;
      logic [XLEN-1:0] mem_addr;
      logic [MW-1:0]   rmask;
      logic [MW-1:0]   wmask;
      logic [XLEN-1:0] mem_rdata;
      logic [XLEN-1:0] mem_wdata;
   } cmp_rec_t;

   logic [TW:0]      r_head;
   logic [TW:0]      r_tail;
   logic [DEPTH-1:0] r_busy;
   logic [DEPTH-1:0] r_done;
   logic             r_halted;
   logic [63:0]      r_count;
   iss_rec_t         r_iss [DEPTH];
   cmp_rec_t         r_cmp [DEPTH];

   logic [TW-1:0]    w_head_idx;
   logic [TW-1:0]    w_tail_idx;
   logic             w_full;
   logic             w_issue;
   logic             w_complete;
   logic             w_retire;
   logic [TW:0]      w_flush_ptr;
   logic [TW:0]      w_flush_cnt;
   logic [DEPTH-1:0] w_squash;
   logic [DEPTH-1:0] w_busy_nxt;
   logic [DEPTH-1:0] w_done_nxt;
   iss_rec_t         w_head_iss;
   cmp_rec_t         w_pkt;

   // Pointer decode, handshake qualification and the flush pointer with its recovered wrap bit
   always_comb begin
      w_head_idx  = r_head[TW-1:0];
      w_tail_idx  = r_tail[TW-1:0];
      w_full      = (w_head_idx == w_tail_idx) && (r_head[TW] != r_tail[TW]);
      o_iss_ready = !w_full && !r_halted;
      o_iss_tag   = w_tail_idx;
      w_issue     = i_iss_valid && o_iss_ready && !i_flush;
      w_retire    = r_busy[w_head_idx] && r_done[w_head_idx] && !r_halted;
      w_flush_ptr = {(i_flush_tag >= w_head_idx) ? r_head[TW] : ~r_head[TW], i_flush_tag};
      w_flush_cnt = r_tail - w_flush_ptr;
   end

   // Slots from flush_tag up to the tail are squashed; a completion aimed at one is dropped
   always_comb begin
      w_squash = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_squash[i] = i_flush && ({1'b0, TW'(i) - i_flush_tag} < w_flush_cnt);
      end
      w_complete = i_cmp_valid && r_busy[i_cmp_tag] && !r_halted && !w_squash[i_cmp_tag];
   end

   // Next busy/done bits: completion, retire, squash, then issue claims the tail slot
   always_comb begin
      w_busy_nxt = r_busy;
      w_done_nxt = r_done;
      if (w_complete) begin
         w_done_nxt[i_cmp_tag] = 1'b1;
      end
      if (w_retire) begin
         w_busy_nxt[w_head_idx] = 1'b0;
         w_done_nxt[w_head_idx] = 1'b0;
      end
      w_busy_nxt = w_busy_nxt & ~w_squash;
      w_done_nxt = w_done_nxt & ~w_squash;
      if (w_issue) begin
         w_busy_nxt[w_tail_idx] = 1'b1;
         w_done_nxt[w_tail_idx] = 1'b0;
      end
   end

   // Head entry with trap, x0 and empty-mask sanitisation applied before it reaches the port
   always_comb begin
      w_head_iss = r_iss[w_head_idx];
      w_pkt      = r_cmp[w_head_idx];
      if (w_pkt.trap) begin
         w_pkt.rd_addr  = '0;
         w_pkt.rd_wdata = '0;
         w_pkt.wmask    = '0;
      end
      if (w_pkt.rd_addr == 5'd0) begin
         w_pkt.rd_wdata = '0;
      end
      if ((w_pkt.rmask == '0) && (w_pkt.wmask == '0)) begin
         w_pkt.mem_addr  = '0;
         w_pkt.mem_rdata = '0;
         w_pkt.mem_wdata = '0;
      end
   end

   // Control state: pointers, per-slot flags, the sticky halt flag and the retirement counter
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_head   <= '0;
         r_tail   <= '0;
         r_busy   <= '0;
         r_done   <= '0;
         r_halted <= 1'b0;
         r_count  <= '0;
      end else begin
         r_busy <= w_busy_nxt;
         r_done <= w_done_nxt;
         if (i_flush) begin
            r_tail <= w_flush_ptr;
         end else if (w_issue) begin
            r_tail <= r_tail + (TW+1)'(1);
         end
         if (w_retire) begin
            r_head  <= r_head + (TW+1)'(1);
            r_count <= r_count + 64'd1;
            if (w_pkt.halt) begin
               r_halted <= 1'b1;
            end
         end
      end
   end

   // Entry payload storage; contents are only meaningful while the slot's busy bit is set
   always_ff @(posedge clock) begin
      if (w_issue) begin
         r_iss[w_tail_idx] <= '{insn: i_iss_insn, intr: i_iss_intr, pc_rdata: i_iss_pc_rdata,
                                rs1_addr: i_iss_rs1_addr, rs2_addr: i_iss_rs2_addr,
                                rs1_rdata: i_iss_rs1_rdata, rs2_rdata: i_iss_rs2_rdata};
      end
      if (w_complete) begin
         r_cmp[i_cmp_tag] <= '{trap: i_cmp_trap, halt: i_cmp_halt, rd_addr: i_cmp_rd_addr,
                               rd_wdata: i_cmp_rd_wdata, pc_wdata: i_cmp_pc_wdata,
                               mem_addr: i_cmp_mem_addr, rmask: i_cmp_mem_rmask,
                               wmask: i_cmp_mem_wmask, mem_rdata: i_cmp_mem_rdata,
                               mem_wdata: i_cmp_mem_wdata};
      end
   end

   // RVFI output registers: a one-cycle valid pulse with the packet held until the next retire
   always_ff @(posedge clock) begin
      if (!reset) begin
         o_rvfi_valid     <= 1'b0;
         o_rvfi_order     <= '0;
         o_rvfi_insn      <= '0;
         o_rvfi_trap      <= 1'b0;
         o_rvfi_halt      <= 1'b0;
         o_rvfi_intr      <= 1'b0;
         o_rvfi_rs1_addr  <= '0;
         o_rvfi_rs2_addr  <= '0;
         o_rvfi_rs1_rdata <= '0;
         o_rvfi_rs2_rdata <= '0;
         o_rvfi_rd_addr   <= '0;
         o_rvfi_rd_wdata  <= '0;
         o_rvfi_pc_rdata  <= '0;
         o_rvfi_pc_wdata  <= '0;
         o_rvfi_mem_addr  <= '0;
         o_rvfi_mem_rmask <= '0;
         o_rvfi_mem_wmask <= '0;
         o_rvfi_mem_rdata <= '0;
         o_rvfi_mem_wdata <= '0;
      end else begin
         o_rvfi_valid <= w_retire;
         if (w_retire) begin
            o_rvfi_order     <= r_count;
            o_rvfi_insn      <= w_head_iss.insn;
            o_rvfi_trap      <= w_pkt.trap;
            o_rvfi_halt      <= w_pkt.halt;
            o_rvfi_intr      <= w_head_iss.intr;
            o_rvfi_rs1_addr  <= w_head_iss.rs1_addr;
            o_rvfi_rs2_addr  <= w_head_iss.rs2_addr;
            o_rvfi_rs1_rdata <= w_head_iss.rs1_rdata;
            o_rvfi_rs2_rdata <= w_head_iss.rs2_rdata;
            o_rvfi_rd_addr   <= w_pkt.rd_addr;
            o_rvfi_rd_wdata  <= w_pkt.rd_wdata;
            o_rvfi_pc_rdata  <= w_head_iss.pc_rdata;
            o_rvfi_pc_wdata  <= w_pkt.pc_wdata;
            o_rvfi_mem_addr  <= w_pkt.mem_addr;
            o_rvfi_mem_rmask <= w_pkt.rmask;
            o_rvfi_mem_wmask <= w_pkt.wmask;
            o_rvfi_mem_rdata <= w_pkt.mem_rdata;
            o_rvfi_mem_wdata <= w_pkt.mem_wdata;
         end
      end
   end

endmodule
